adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: W, default 64, operand/result width in bits.
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester n holds an add request.
REQ-005 req0_a, req0_b / req1_a, req1_b  input  W  signed two's-complement operands of requester n.
REQ-006 req0_ready / req1_ready  output  1  request n accepted this cycle when valid && ready.
REQ-007 rsp_valid  output  1  response register holds a result.
REQ-008 rsp_id  output  1  index of the requester that owns the result.
REQ-009 rsp_sum  output  W  a+b modulo 2^W.
REQ-010 rsp_ovf  output  1  signed overflow of that addition.
REQ-011 rsp_ready  input  1  consumer takes the response when rsp_valid && rsp_ready.
REQ-012 ovf_sticky  output  1  accumulated overflow flag (see Configuration).
REQ-013 ovf_clr  input  1  clears ovf_sticky.

Function
REQ-014 One shared W-bit adder serves both requesters; at most one request is accepted per cycle.
REQ-015 can_accept = !rsp_valid || rsp_ready (single-entry response register, empty or draining this cycle).
REQ-016 Arbitration is round-robin: only one valid -> it wins; both valid -> the requester not granted last wins.
REQ-017 reqN_ready = can_accept && (requester N wins); ready depends combinationally on valid, never the reverse.
REQ-018 last_grant updates only on an actual acceptance; no acceptance leaves it unchanged.
REQ-019 Latency: request accepted in cycle N -> rsp_valid=1 with its rsp_id/rsp_sum/rsp_ovf from cycle N+1.
REQ-020 While rsp_valid && !rsp_ready, rsp_id, rsp_sum and rsp_ovf hold stable and both ready outputs are 0.
REQ-021 Drain and accept in same cycle: new result replaces old next cycle, rsp_valid stays 1 (full throughput, one result per cycle).
REQ-022 Drain without acceptance: rsp_valid falls to 0 next cycle.
REQ-023 rsp_ovf = (a[W-1]==b[W-1]) && (sum[W-1]!=a[W-1]); carry out of bit W-1 is discarded.
REQ-024 Response register states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); EMPTY->FULL on accept, FULL->EMPTY on drain without accept, otherwise hold.

Reset
REQ-025 rst_n low asynchronously forces rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_ovf=0, ovf_sticky=0, last_grant=1 (req0 wins first contention).
REQ-026 Reset mid-operation discards any held response; no result is delivered for requests accepted before reset.
REQ-027 While rst_n is low, req0_ready and req1_ready are 0.

Configuration
REQ-028 Macro ADDER_ARB_OVF_STICKY_EN defined: ovf_sticky sets on every acceptance whose result overflows, clears on ovf_clr; set and clear in the same cycle -> set wins.
REQ-029 Macro undefined: ovf_sticky is constant 0, ovf_clr ignored; ports remain present.

Structure
REQ-030 Package adder_arb_pkg holds W default (64), the requester-id type (1 bit) and the reset last_grant constant.
REQ-031 The adder datapath is one instance of the existing adder64x1 (a, b -> sum, overflow); no second adder.

Verification
REQ-032 Single req0: a=1134, b=8238, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=9372, rsp_ovf=0.
REQ-033 Both valid every cycle after reset, rsp_ready=1: req0 a=2,b=-13; req1 a=-7478,b=-46474 -> grants alternate 0,1,0,1; sums -11 and -53952.
REQ-034 Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1 -> rsp_sum=0x8000_0000_0000_0000, rsp_ovf=1; with macro ovf_sticky=1 until ovf_clr pulse; without macro ovf_sticky=0.
REQ-035 Backpressure: rsp_ready=0 for 3 cycles with a=-1,b=-1 result held -> rsp_sum=-2, rsp_ovf=0 stable, both readies 0; rsp_ready=1 with req1 valid -> accepted same cycle, new result next cycle.
REQ-036 Reset mid-operation: rst_n low while rsp_valid=1 -> rsp_valid=0 immediately (no clock edge); after release, first contention grants req0.
REQ-037 Simultaneous ovf_clr and overflowing acceptance (macro defined) -> ovf_sticky=1 next cycle.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared width default, requester-id type and reset grant state for adder_arbiter.
package adder_arb_pkg;
  localparam int W_DEF = 64;
  typedef logic id_t;
  localparam id_t LAST_GRANT_RST = 1'b1;
endpackage

// File: rtl/adder64x1.sv
// adder64x1: W-bit two's-complement adder with signed overflow; carry out is discarded.
module adder64x1
  import adder_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);
  assign sum = a + b;
  assign ovf = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one adder between two requesters, single-entry response register.
// Define ADDER_ARB_OVF_STICKY_EN to enable the accumulated overflow flag ovf_sticky.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic         req1_ready,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_sum,
  output logic         rsp_ovf,
  input  logic         rsp_ready,
  output logic         ovf_sticky,
  input  logic         ovf_clr
);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;
  logic [0:0]   st;
  id_t          last_grant;
  id_t          sel;
  logic         can_accept;
  logic         win0;
  logic         win1;
  logic         accept;
  logic [W-1:0] sum;
  logic         ovf;
  assign can_accept = !rsp_valid || rsp_ready;
  assign win0       = req0_valid && (!req1_valid || last_grant == 1'b1);
  assign win1       = req1_valid && (!req0_valid || last_grant == 1'b0);
  // rst_n gating keeps readies low during reset, when the empty register would otherwise accept
  assign req0_ready = rst_n && can_accept && win0;
  assign req1_ready = rst_n && can_accept && win1;
  assign accept     = req0_ready || req1_ready;
  assign sel        = win1;
  assign rsp_valid  = (st == FULL);
  adder64x1 #(.W(W)) u_add (
    .a  (sel ? req1_a : req0_a),
    .b  (sel ? req1_b : req0_b),
    .sum(sum),
    .ovf(ovf)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= EMPTY;
      rsp_id     <= 1'b0;
      rsp_sum    <= '0;
      rsp_ovf    <= 1'b0;
      last_grant <= LAST_GRANT_RST;
    end else begin
      st <= accept ? FULL : (rsp_ready ? EMPTY : st);
      if (accept) begin
        rsp_id     <= sel;
        rsp_sum    <= sum;
        rsp_ovf    <= ovf;
        last_grant <= sel;
      end
    end
  end
`ifdef ADDER_ARB_OVF_STICKY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_sticky <= 1'b0;
    else if (accept && ovf) ovf_sticky <= 1'b1;
    else if (ovf_clr) ovf_sticky <= 1'b0;
  end
`else
  logic unused_clr;
  assign unused_clr = ovf_clr;
  assign ovf_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: table-driven directed vectors plus reset-in-flight sequence for adder_arbiter.
module tb_adder_arbiter;
  localparam int W = 64;
`ifdef ADDER_ARB_OVF_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_ovf, ovf_sticky;
  logic [W-1:0] rsp_sum;
  logic         rsp_ready = 1'b1;
  logic         ovf_clr = 1'b0;
  int           total = 0;
  int           bad = 0;
  typedef struct {
    logic v0, v1;
    logic [W-1:0] a0, b0, a1, b1;
    logic rr, clr;
    logic e_r0, e_r1, e_v, e_id;
    logic [W-1:0] e_sum;
    logic e_ovf, e_st;
  } vec_t;
  vec_t tv[$];
  adder_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ovf(rsp_ovf),
    .rsp_ready(rsp_ready), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  task automatic add(input logic v0, input logic v1, input logic [W-1:0] a0, input logic [W-1:0] b0,
                     input logic [W-1:0] a1, input logic [W-1:0] b1, input logic rr, input logic clr,
                     input logic e_r0, input logic e_r1, input logic e_v, input logic e_id,
                     input logic [W-1:0] e_sum, input logic e_ovf, input logic e_st);
    vec_t t;
    t.v0 = v0; t.v1 = v1; t.a0 = a0; t.b0 = b0; t.a1 = a1; t.b1 = b1; t.rr = rr; t.clr = clr;
    t.e_r0 = e_r0; t.e_r1 = e_r1; t.e_v = e_v; t.e_id = e_id; t.e_sum = e_sum; t.e_ovf = e_ovf; t.e_st = e_st;
    tv.push_back(t);
  endtask
  initial begin
    logic [W-1:0] maxp, minn, m2, m11, m53952;
    maxp = 64'h7FFF_FFFF_FFFF_FFFF;
    minn = 64'h8000_0000_0000_0000;
    m2 = -64'sd2; m11 = -64'sd11; m53952 = -64'sd53952;
    // v0 v1 a0 b0 a1 b1 rr clr | r0 r1 valid id sum ovf sticky(if enabled)
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 2, -13, -7478, -46474, 1, 0, 1, 0, 1, 0, m11, 0, 0);
    add(1, 1, 2, -13, -7478, -46474, 1, 0, 0, 1, 1, 1, m53952, 0, 0);
    add(1, 1, 2, -13, -7478, -46474, 1, 0, 1, 0, 1, 0, m11, 0, 0);
    add(1, 1, 2, -13, -7478, -46474, 1, 0, 0, 1, 1, 1, m53952, 0, 0);
    add(1, 0, 1134, 8238, 0, 0, 1, 0, 1, 0, 1, 0, 9372, 0, 0);
    add(0, 1, 0, 0, maxp, 1, 1, 0, 0, 1, 1, 1, minn, 1, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, minn, -1, 0, 0, 1, 1, 1, 0, 1, 0, maxp, 1, 1);
    add(1, 1, 9, 9, 9, 9, 0, 0, 0, 0, 1, 0, maxp, 1, 1);
    add(1, 0, -1, -1, 0, 0, 1, 0, 1, 0, 1, 0, m2, 0, 1);
    add(1, 1, 7, 7, 8, 8, 0, 0, 0, 0, 1, 0, m2, 0, 1);
    add(1, 1, 7, 7, 8, 8, 0, 0, 0, 0, 1, 0, m2, 0, 1);
    add(0, 1, 7, 7, 8, 8, 0, 0, 0, 0, 1, 0, m2, 0, 1);
    add(0, 1, 0, 0, 5, 6, 1, 0, 0, 1, 1, 1, 11, 0, 1);
    add(1, 0, -1, 1, 0, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.r0", 64'(req0_ready), 0);
    chk("rst.r1", 64'(req1_ready), 0);
    chk("rst.valid", 64'(rsp_valid), 0);
    chk("rst.id", 64'(rsp_id), 0);
    chk("rst.sum", rsp_sum, 0);
    chk("rst.ovf", 64'(rsp_ovf), 0);
    chk("rst.sticky", 64'(ovf_sticky), 0);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    foreach (tv[i]) begin
      @(negedge clk);
      req0_valid = tv[i].v0; req1_valid = tv[i].v1;
      req0_a = tv[i].a0; req0_b = tv[i].b0; req1_a = tv[i].a1; req1_b = tv[i].b1;
      rsp_ready = tv[i].rr; ovf_clr = tv[i].clr;
      #1;
      chk($sformatf("v%0d.r0", i), 64'(req0_ready), 64'(tv[i].e_r0));
      chk($sformatf("v%0d.r1", i), 64'(req1_ready), 64'(tv[i].e_r1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.valid", i), 64'(rsp_valid), 64'(tv[i].e_v));
      if (tv[i].e_v) begin
        chk($sformatf("v%0d.id", i), 64'(rsp_id), 64'(tv[i].e_id));
        chk($sformatf("v%0d.sum", i), rsp_sum, tv[i].e_sum);
        chk($sformatf("v%0d.ovf", i), 64'(rsp_ovf), 64'(tv[i].e_ovf));
      end
      chk($sformatf("v%0d.sticky", i), 64'(ovf_sticky), 64'(tv[i].e_st & STICKY));
    end
    // reset while a response is held: cleared without a clock edge, and nothing resurfaces
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b0; req0_a = 3; req0_b = 4; rsp_ready = 1'b0; ovf_clr = 1'b0;
    @(posedge clk);
    #1;
    chk("mid.valid_pre", 64'(rsp_valid), 1);
    chk("mid.sum_pre", rsp_sum, 7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.valid", 64'(rsp_valid), 0);
    chk("mid.sum", rsp_sum, 0);
    chk("mid.sticky", 64'(ovf_sticky), 0);
    chk("mid.r0", 64'(req0_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post.valid_idle", 64'(rsp_valid), 0);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1; req0_a = 10; req0_b = 20; req1_a = 30; req1_b = 40;
    #1;
    chk("post.r0", 64'(req0_ready), 1);
    chk("post.r1", 64'(req1_ready), 0);
    @(posedge clk);
    #1;
    chk("post.id", 64'(rsp_id), 0);
    chk("post.sum", rsp_sum, 30);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
